// File: rtl/edge_delay_meter_pkg.sv
// Shared types and default sizing for the edge-to-edge delay meter.
package edge_delay_meter_pkg;
  localparam int CNT_W_DEF   = 8;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/edge_delay_meter_rise_edge_detect.sv
// Registered-previous-sample rising edge detector; rise is combinational on the current input.
module rise_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);
  logic prev_p0;

  always_ff @(posedge clk) begin
    if (rst) prev_p0 <= 1'b0;
    else     prev_p0 <= in;
  end

  assign rise = in & ~prev_p0;
endmodule

// File: rtl/edge_delay_meter.sv
// Measures cycles from a start rising edge to a stop rising edge, with timeout and min/max stats.
module edge_delay_meter
  import edge_delay_meter_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_in,
  input  logic             stop_in,
  input  logic             result_ack,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] delay,
  output logic             result_valid,
  output logic             timeout,
  output logic             busy,
  output logic [CNT_W-1:0] delay_min,
  output logic [CNT_W-1:0] delay_max,
  output logic             overrun
);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  state_t           state, state_n;
  logic             start_rise, stop_rise;
  logic [CNT_W-1:0] cnt;
  logic             load, load_to, cnt_start, cnt_inc;
  logic [CNT_W-1:0] load_val;

  rise_edge_detect u_start_edge (.clk(clk), .rst(rst), .in(start_in), .rise(start_rise));
  rise_edge_detect u_stop_edge  (.clk(clk), .rst(rst), .in(stop_in),  .rise(stop_rise));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start_rise) state_n = stop_rise ? DONE : COUNT;
      COUNT:   if (stop_rise || cnt == TMO) state_n = DONE;
      DONE:    if (result_ack) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // A stop edge on the timeout cycle still yields a normal result.
  always_comb begin
    load      = 1'b0;
    load_to   = 1'b0;
    load_val  = '0;
    cnt_start = 1'b0;
    cnt_inc   = 1'b0;
    busy      = (state == COUNT);
    case (state)
      IDLE: begin
        if (start_rise && stop_rise) load = 1'b1;
        else if (start_rise)         cnt_start = 1'b1;
      end
      COUNT: begin
        if (stop_rise) begin
          load     = 1'b1;
          load_val = cnt;
        end else if (cnt == TMO) begin
          load     = 1'b1;
          load_to  = 1'b1;
          load_val = TMO;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      delay        <= '0;
      timeout      <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      if (cnt_start)    cnt <= CNT_W'(1);
      else if (cnt_inc) cnt <= cnt + CNT_W'(1);
      if (load) begin
        delay        <= load_val;
        timeout      <= load_to;
        result_valid <= 1'b1;
      end else if (state == DONE && result_ack) begin
        result_valid <= 1'b0;
      end
    end
  end

  // Clear outranks a same-cycle statistics update.
  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      delay_min <= '1;
      delay_max <= '0;
      overrun   <= 1'b0;
    end else begin
      if (start_rise && state != IDLE) overrun <= 1'b1;
      if (load && !load_to) begin
        if (load_val < delay_min) delay_min <= load_val;
        if (load_val > delay_max) delay_max <= load_val;
      end
    end
  end
endmodule

// File: tb/tb_edge_delay_meter.sv
// Directed bench for edge_delay_meter with a timestamp-based reference model.
module tb_edge_delay_meter;
  localparam int TMO = 255;

  logic       clk = 1'b0;
  logic       rst, start_in, stop_in, result_ack, stats_clr;
  logic [7:0] delay, delay_min, delay_max;
  logic       result_valid, timeout, busy, overrun;

  int checks   = 0;
  int failures = 0;

  edge_delay_meter dut (
    .clk(clk), .rst(rst), .start_in(start_in), .stop_in(stop_in),
    .result_ack(result_ack), .stats_clr(stats_clr), .delay(delay),
    .result_valid(result_valid), .timeout(timeout), .busy(busy),
    .delay_min(delay_min), .delay_max(delay_max), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0=waiting, 1=measuring since cycle t0, 2=holding a result.
  int  n = 0, t0 = 0, phase = 0, d;
  bit  ps, pp, sr, pr, got, gto, model_on = 0;
  int  e_delay, e_min, e_max;
  bit  e_valid, e_to, e_ovr;

  always @(posedge clk) begin
    n++;
    if (rst) begin
      phase = 0; ps = 0; pp = 0;
      e_delay = 0; e_min = 255; e_max = 0; e_valid = 0; e_to = 0; e_ovr = 0;
    end else begin
      sr = start_in && !ps; pr = stop_in && !pp;
      ps = start_in; pp = stop_in;
      got = 0; gto = 0; d = 0;
      case (phase)
        0: if (sr) begin t0 = n; if (pr) got = 1; else phase = 1; end
        1: begin
          if (sr) e_ovr = 1;
          d = n - t0;
          if (pr) got = 1;
          else if (d == TMO) begin got = 1; gto = 1; end
        end
        default: begin
          if (sr) e_ovr = 1;
          if (result_ack) begin phase = 0; e_valid = 0; end
        end
      endcase
      if (got) begin
        phase = 2; e_delay = d; e_to = gto; e_valid = 1;
        if (!gto) begin
          if (d < e_min) e_min = d;
          if (d > e_max) e_max = d;
        end
      end
      if (stats_clr) begin e_min = 255; e_max = 0; e_ovr = 0; end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("delay", delay, e_delay);
      chk("result_valid", result_valid, e_valid);
      chk("timeout", timeout, e_to);
      chk("busy", busy, phase == 1);
      chk("delay_min", delay_min, e_min);
      chk("delay_max", delay_max, e_max);
      chk("overrun", overrun, e_ovr);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic ack();
    result_ack = 1; tick(); result_ack = 0;
    chk("valid_after_ack", result_valid, 0);
  endtask

  // Start rises at t0, stop rises at t0+dl (dl >= 1).
  task automatic measure(input int dl);
    start_in = 1; tick();
    repeat (dl - 1) tick();
    stop_in = 1; tick();
    chk("lit_valid", result_valid, 1);
    chk("lit_delay", delay, dl);
    chk("lit_timeout", timeout, 0);
    start_in = 0; stop_in = 0;
  endtask

  initial begin
    rst = 1; start_in = 0; stop_in = 0; result_ack = 0; stats_clr = 0;
    repeat (2) tick();
    rst = 0; model_on = 1;
    chk("rst_delay", delay, 0);
    chk("rst_min", delay_min, 255);
    chk("rst_valid", result_valid, 0);

    measure(14);
    chk("lit_min14", delay_min, 14);
    chk("lit_max14", delay_max, 14);
    ack();

    // ack outside DONE does nothing
    result_ack = 1; tick(); result_ack = 0; tick();

    measure(3);  ack();
    measure(20); ack();
    chk("lit_min3", delay_min, 3);
    chk("lit_max20", delay_max, 20);

    // start and stop rise together
    start_in = 1; stop_in = 1; tick();
    chk("lit_d0", delay, 0);
    chk("lit_d0_to", timeout, 0);
    chk("lit_d0_valid", result_valid, 1);
    start_in = 0; stop_in = 0; ack();

    // timeout, stats unchanged
    start_in = 1; tick(); start_in = 0;
    repeat (260) tick();
    chk("lit_to_delay", delay, 255);
    chk("lit_to_flag", timeout, 1);
    chk("lit_to_min", delay_min, 0);
    chk("lit_to_max", delay_max, 20);
    ack();

    // stop on the timeout cycle wins
    measure(255);
    chk("lit_tie_max", delay_max, 255);
    ack();

    // second start during COUNT
    start_in = 1; tick();
    start_in = 0; tick();
    start_in = 1; tick();
    tick(); tick();
    stop_in = 1; tick();
    chk("lit_ovr_delay", delay, 5);
    chk("lit_ovr", overrun, 1);
    start_in = 0; stop_in = 0; ack();
    stats_clr = 1; tick(); stats_clr = 0;
    chk("lit_clr_ovr", overrun, 0);
    chk("lit_clr_min", delay_min, 255);
    chk("lit_clr_max", delay_max, 0);

    // clear coinciding with an update
    start_in = 1; stop_in = 1; stats_clr = 1; tick();
    stats_clr = 0; start_in = 0; stop_in = 0;
    chk("lit_clrwin_min", delay_min, 255);
    ack();

    // reset mid-measurement at cnt=7
    start_in = 1; tick();
    repeat (6) tick();
    chk("lit_busy", busy, 1);
    rst = 1; start_in = 0; tick(); rst = 0;
    chk("lit_rst_busy", busy, 0);
    chk("lit_rst_delay", delay, 0);
    chk("lit_rst_max", delay_max, 0);
    stop_in = 1; tick(); tick(); stop_in = 0;
    chk("lit_rst_novalid", result_valid, 0);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
